// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte FIFO and frame pacer feeding uart_tx, which has no busy output of its
// own. Bytes written over a valid/ready port are launched one per frame time
// as a single-cycle tx_data_ready strobe; tx_busy is high while a frame
// (plus guard time) is considered in flight.
//
// Ports:
//   clk_fast, rst_n      clock (rising edge), async active-low reset
//   wr_valid, wr_data    write request and byte; accepted when wr_ready
//   wr_ready             !full
//   tx_data              registered byte to uart_tx.data_in
//   tx_data_ready        registered one-cycle launch strobe to uart_tx.data_ready
//   tx_busy              high while a frame is being paced (HOLD)
//   level, empty, full   occupancy
//   ovf_clr, ovf         sticky overflow flag and its clear; present only when
//                        UART_TX_FIFO_OVF_EN is defined
//
// state | meaning
// IDLE  | nothing in flight; launch as soon as the FIFO is non-empty
// HOLD  | frame in flight; counter runs down to 0, then launch next or go IDLE

module uart_tx_fifo #(
   parameter int CLOCK_FREQ   = 81000000,
   parameter int BAUD_RATE    = 3000000,
   parameter int DEPTH        = 16,
   parameter int FRAME_BITS   = 10,
   parameter int GUARD_CYCLES = 2
) (
   input  logic                   clk_fast,
   input  logic                   rst_n,
   input  logic                   wr_valid,
   input  logic [7:0]             wr_data,
   output logic                   wr_ready,
   output logic [7:0]             tx_data,
   output logic                   tx_data_ready,
   output logic                   tx_busy,
   output logic [$clog2(DEPTH):0] level,
   output logic                   empty,
   output logic                   full
`ifdef UART_TX_FIFO_OVF_EN
   ,
   input  logic                   ovf_clr,
   output logic                   ovf
`endif
);

   localparam int BIT_CYCLES   = CLOCK_FREQ / BAUD_RATE;
   localparam int FRAME_CYCLES = BIT_CYCLES * FRAME_BITS + GUARD_CYCLES;
   localparam int CNT_W        = $clog2(FRAME_CYCLES);
   localparam int PTR_W        = $clog2(DEPTH);
   localparam int LVL_W        = PTR_W + 1;

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_data_ready_q, tx_data_ready_d;
   logic [7:0]       mem_q [DEPTH];
   logic [7:0]       mem_d [DEPTH];
   logic             wr_en;
   logic             launch;
`ifdef UART_TX_FIFO_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   assign empty         = (level_q == '0);
   assign full          = (level_q == LVL_W'(DEPTH));
   assign wr_ready      = !full;
   assign level         = level_q;
   assign tx_data       = tx_data_q;
   assign tx_data_ready = tx_data_ready_q;
   assign tx_busy       = (state_q == HOLD);

   // A write while full is dropped even if a pop frees a slot on the same edge.
   assign wr_en = wr_valid && !full;

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      rd_ptr_d        = rd_ptr_q;
      tx_data_d       = tx_data_q;
      tx_data_ready_d = 1'b0;
      launch          = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (!empty) launch = 1'b1;
         end
         HOLD: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else if (!empty) begin
               launch = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Counter loads FRAME_CYCLES-1 so the next launch edge lands exactly
      // FRAME_CYCLES clocks after this one.
      if (launch) begin
         tx_data_d       = mem_q[rd_ptr_q];
         tx_data_ready_d = 1'b1;
         rd_ptr_d        = rd_ptr_q + PTR_W'(1);
         cnt_d           = CNT_W'(FRAME_CYCLES - 1);
         state_d         = HOLD;
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end

      unique case ({wr_en, launch})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

`ifdef UART_TX_FIFO_OVF_EN
   // Set has priority over clear.
   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (wr_valid && !wr_ready) ovf_d = 1'b1;
   end

   assign ovf = ovf_q;
`endif

   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         cnt_q           <= '0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         level_q         <= '0;
         tx_data_q       <= 8'h00;
         tx_data_ready_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
`ifdef UART_TX_FIFO_OVF_EN
         ovf_q           <= 1'b0;
`endif
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         level_q         <= level_d;
         tx_data_q       <= tx_data_d;
         tx_data_ready_q <= tx_data_ready_d;
         mem_q           <= mem_d;
`ifdef UART_TX_FIFO_OVF_EN
         ovf_q           <= ovf_d;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
   localparam int CLOCK_FREQ   = 81000000;
   localparam int BAUD_RATE    = 3000000;
   localparam int DEPTH        = 16;
   localparam int FRAME_BITS   = 10;
   localparam int GUARD_CYCLES = 2;
   localparam int FRAME        = (CLOCK_FREQ / BAUD_RATE) * FRAME_BITS + GUARD_CYCLES;
   localparam int LW           = $clog2(DEPTH) + 1;
   localparam int VW           = LW + 13;

   logic          clk_fast = 1'b0;
   logic          rst_n    = 1'b0;
   logic          wr_valid = 1'b0;
   logic [7:0]    wr_data  = 8'h00;
   logic          wr_ready;
   logic [7:0]    tx_data;
   logic          tx_data_ready;
   logic          tx_busy;
   logic [LW-1:0] level;
   logic          empty;
   logic          full;
`ifdef UART_TX_FIFO_OVF_EN
   logic          ovf_clr = 1'b0;
   logic          ovf;
`endif

   int checks = 0;
   int errors = 0;

   uart_tx_fifo #(
      .CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE), .DEPTH(DEPTH),
      .FRAME_BITS(FRAME_BITS), .GUARD_CYCLES(GUARD_CYCLES)
   ) dut (
      .clk_fast(clk_fast), .rst_n(rst_n), .wr_valid(wr_valid), .wr_data(wr_data),
      .wr_ready(wr_ready), .tx_data(tx_data), .tx_data_ready(tx_data_ready),
      .tx_busy(tx_busy), .level(level), .empty(empty), .full(full)
`ifdef UART_TX_FIFO_OVF_EN
      , .ovf_clr(ovf_clr), .ovf(ovf)
`endif
   );

   always #5 clk_fast = ~clk_fast;

   // Reference model: a byte queue plus "earliest next launch" time.
   // A launch happens on an edge when the queue is non-empty and the previous
   // launch was at least FRAME edges ago; busy means a frame window is open.
   byte unsigned mq[$];
   logic [7:0]   m_tx;
   logic         m_rdy, m_busy, m_ovf;
   int           m_edge, m_next;

   initial begin
      bit launch, acc, rej;
      m_tx = 8'h00; m_rdy = 1'b0; m_busy = 1'b0; m_ovf = 1'b0;
      m_edge = 0; m_next = 0;
      forever begin
         @(posedge clk_fast or negedge rst_n);
         if (!rst_n) begin
            mq.delete();
            m_tx = 8'h00; m_rdy = 1'b0; m_busy = 1'b0; m_ovf = 1'b0; m_next = 0;
         end else begin
            launch = (mq.size() != 0) && (m_edge >= m_next);
            acc    = wr_valid && (mq.size() < DEPTH);
            rej    = wr_valid && !acc;
            m_rdy  = launch;
            if (launch) begin
               m_tx   = mq.pop_front();
               m_next = m_edge + FRAME;
            end
            if (acc) mq.push_back(wr_data);
            m_busy = (m_edge < m_next);
`ifdef UART_TX_FIFO_OVF_EN
            if (rej) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
`endif
            m_edge++;
         end
      end
   end

   function automatic logic [VW-1:0] model_vec();
      int n = mq.size();
      return {m_rdy, m_tx, m_busy, LW'(n), n == 0, n == DEPTH, n != DEPTH};
   endfunction

   wire [VW-1:0] dut_vec = {tx_data_ready, tx_data, tx_busy, level, empty, full, wr_ready};

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk_fast);
      checks++;
      if ({tx_data, tx_data_ready, tx_busy, level, empty, full, wr_ready} !==
          {8'h00, 1'b0, 1'b0, LW'(0), 1'b1, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL reset_values: got data=%h rdy=%b busy=%b lvl=%0d e=%b f=%b wr=%b",
                  tx_data, tx_data_ready, tx_busy, level, empty, full, wr_ready);
      end
`ifdef UART_TX_FIFO_OVF_EN
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b exp 0", ovf); end
`endif
      rst_n = 1'b1;
      @(negedge clk_fast);
   endtask

   task automatic test_single();
      int strobes, busy_cnt;
      wr_valid = 1'b1; wr_data = 8'h5A;
      @(negedge clk_fast);
      wr_valid = 1'b0;
      checks++;
      if (level !== LW'(1) || empty !== 1'b0 || tx_data_ready !== 1'b0) begin
         errors++;
         $display("FAIL single_after_write: lvl=%0d empty=%b rdy=%b exp 1/0/0", level, empty, tx_data_ready);
      end
      @(negedge clk_fast);
      checks++;
      if (tx_data_ready !== 1'b1 || tx_data !== 8'h5A) begin
         errors++;
         $display("FAIL single_strobe: rdy=%b data=%h exp 1/5a", tx_data_ready, tx_data);
      end
      strobes  = 1;
      busy_cnt = (tx_busy === 1'b1) ? 1 : 0;
      repeat (FRAME + 20) begin
         @(negedge clk_fast);
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL single_lockstep: got %h exp %h", dut_vec, model_vec());
         end
         strobes  += (tx_data_ready === 1'b1) ? 1 : 0;
         busy_cnt += (tx_busy === 1'b1) ? 1 : 0;
      end
      checks++;
      if (strobes != 1 || busy_cnt != 272 || empty !== 1'b1) begin
         errors++;
         $display("FAIL single_summary: strobes=%0d busy=%0d empty=%b exp 1/272/1", strobes, busy_cnt, empty);
      end
   endtask

   task automatic test_back_to_back();
      int t, first, nstr;
      logic [7:0] exp_b;
      t = 0; first = -1; nstr = 0;
      for (int i = 0; i < 3 * FRAME + 10; i++) begin
         wr_valid = (i < 3);
         wr_data  = 8'(i + 1);
         @(negedge clk_fast);
         t++;
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL b2b_lockstep: t=%0d got %h exp %h", t, dut_vec, model_vec());
         end
         if (tx_data_ready === 1'b1) begin
            exp_b = 8'(nstr + 1);
            if (first < 0) first = t;
            checks++;
            if (tx_data !== exp_b || t != first + nstr * FRAME || level !== LW'(nstr == 0 ? 1 : 2 - nstr)) begin
               errors++;
               $display("FAIL b2b_strobe: n=%0d t=%0d data=%h lvl=%0d exp t=%0d data=%h",
                        nstr, t, tx_data, level, first + nstr * FRAME, exp_b);
            end
            nstr++;
         end
      end
      wr_valid = 1'b0;
      checks++;
      if (nstr != 3 || first != 2) begin
         errors++;
         $display("FAIL b2b_count: strobes=%0d first=%0d exp 3/2", nstr, first);
      end
   endtask

   task automatic test_full();
      bit saw_ee;
      wr_valid = 1'b1; wr_data = 8'hA0;
      @(negedge clk_fast);
      for (int i = 0; i < DEPTH; i++) begin
         wr_data = 8'($urandom_range(0, 8'hED));
         @(negedge clk_fast);
      end
      checks++;
      if (full !== 1'b1 || wr_ready !== 1'b0 || level !== LW'(DEPTH)) begin
         errors++;
         $display("FAIL full_flags: full=%b wr_ready=%b lvl=%0d exp 1/0/%0d", full, wr_ready, level, DEPTH);
      end
      wr_data = 8'hEE;
      @(negedge clk_fast);
`ifdef UART_TX_FIFO_OVF_EN
      checks++;
      if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b exp 1", ovf); end
      ovf_clr = 1'b1;
      @(negedge clk_fast);
      checks++;
      if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %b exp 1", ovf); end
      wr_valid = 1'b0;
      @(negedge clk_fast);
      ovf_clr = 1'b0;
      checks++;
      if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b exp 0", ovf); end
`endif
      wr_valid = 1'b0;
      saw_ee = 1'b0;
      repeat ((DEPTH + 1) * FRAME) begin
         @(negedge clk_fast);
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL full_lockstep: got %h exp %h", dut_vec, model_vec());
         end
         if (tx_data_ready === 1'b1 && tx_data === 8'hEE) saw_ee = 1'b1;
      end
      checks++;
      if (saw_ee || empty !== 1'b1) begin
         errors++;
         $display("FAIL full_drop: saw_ee=%b empty=%b exp 0/1", saw_ee, empty);
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 20; i++) begin
         wr_valid = 1'b1; wr_data = 8'($urandom);
         repeat ($urandom_range(FRAME - 3, FRAME + 3)) begin
            @(negedge clk_fast);
            wr_valid = 1'b0;
            checks++;
            if (dut_vec !== model_vec()) begin
               errors++;
               $display("FAIL wrap_lockstep: i=%0d got %h exp %h", i, dut_vec, model_vec());
            end
         end
      end
   endtask

   task automatic test_random();
      repeat (3000) begin
         wr_valid = ($urandom_range(0, 7) == 0);
         wr_data  = 8'($urandom);
`ifdef UART_TX_FIFO_OVF_EN
         ovf_clr  = ($urandom_range(0, 15) == 0);
`endif
         @(negedge clk_fast);
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL random_lockstep: got %h exp %h", dut_vec, model_vec());
         end
`ifdef UART_TX_FIFO_OVF_EN
         checks++;
         if (ovf !== m_ovf) begin errors++; $display("FAIL random_ovf: got %b exp %b", ovf, m_ovf); end
`endif
      end
      wr_valid = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
      ovf_clr = 1'b0;
`endif
   endtask

   task automatic test_reset_mid();
      int strobes;
      rst_n = 1'b0;
      @(negedge clk_fast);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         wr_valid = 1'b1; wr_data = 8'(8'h30 + i);
         @(negedge clk_fast);
      end
      wr_valid = 1'b0;
      repeat (50) @(negedge clk_fast);
      checks++;
      if (level !== LW'(5) || tx_busy !== 1'b1) begin
         errors++;
         $display("FAIL midrst_pre: lvl=%0d busy=%b exp 5/1", level, tx_busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({tx_data, tx_data_ready, tx_busy, level, empty, full, wr_ready} !==
          {8'h00, 1'b0, 1'b0, LW'(0), 1'b1, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL midrst_async: data=%h rdy=%b busy=%b lvl=%0d e=%b f=%b wr=%b",
                  tx_data, tx_data_ready, tx_busy, level, empty, full, wr_ready);
      end
      @(negedge clk_fast);
      rst_n = 1'b1;
      strobes = 0;
      repeat (2 * FRAME) begin
         @(negedge clk_fast);
         strobes += (tx_data_ready === 1'b1) ? 1 : 0;
         checks++;
         if (dut_vec !== model_vec()) begin
            errors++;
            $display("FAIL midrst_lockstep: got %h exp %h", dut_vec, model_vec());
         end
      end
      checks++;
      if (strobes != 0) begin errors++; $display("FAIL midrst_no_strobe: got %0d exp 0", strobes); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
